// File: rtl/mem_byte_initiator.sv
// Byte-serial load/store initiator: one RAM byte per cycle, little-endian,
// with sign/zero extension of load data and a single-cycle response pulse.
module mem_byte_initiator #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_mode,
    input  logic [WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [WIDTH-1:0]     resp_rdata,
    output logic                 resp_err,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_we;
    logic [2:0]           r_mode;
    logic [ADDR_BITS-1:0] r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [1:0]           r_idx;
    logic [WIDTH-1:0]     r_asm;
    logic                 r_err;
    logic                 w_unused_addr;

    assign w_unused_addr = ^req_addr[WIDTH-1:ADDR_BITS];

    // Index of the final byte: stores in modes 100/101 share the 010/011 counts.
    function automatic logic [1:0] last_idx(input logic [2:0] mode);
        case (mode)
            3'b001:         return 2'd3;
            3'b010, 3'b100: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode != 3'b000) && (mode < 3'b110);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = mode_legal(req_mode) ? ACCESS : RESP;
            ACCESS:  if (r_idx == last_idx(r_mode)) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_mode  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    r_asm <= '0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_mode  <= req_mode;
                        r_addr  <= req_addr[ADDR_BITS-1:0];
                        r_wdata <= req_wdata;
                        r_err   <= !mode_legal(req_mode);
                    end
                end
                ACCESS: begin
                    if (!r_we) r_asm[{r_idx, 3'b000} +: 8] <= mem_rdata;
                    r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // mem_we is gated by rst_n so a reset edge mid-store writes nothing.
    always_comb begin
        req_ready  = 1'b0;
        busy       = (r_state != IDLE);
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (r_state)
            IDLE: req_ready = rst_n;
            ACCESS: begin
                mem_addr = r_addr + ADDR_BITS'(r_idx);
                mem_we   = rst_n && r_we;
                if (r_we) mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_we && !r_err) begin
                    case (r_mode)
                        3'b010:  resp_rdata = {{(WIDTH-16){r_asm[15]}}, r_asm[15:0]};
                        3'b011:  resp_rdata = {{(WIDTH-8){r_asm[7]}}, r_asm[7:0]};
                        default: resp_rdata = r_asm;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed bench for mem_byte_initiator with a behavioural byte RAM.
module tb_mem_byte_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:131071];
    int          errors = 0;
    int          checks = 0;

    mem_byte_initiator #(.WIDTH(32), .ADDR_BITS(17)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge (edge T); returns in cycle T+1.
    task automatic issue(input logic we, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h0 || mem_wdata !== 8'h0)
            begin errors++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h want 0/0/0", mem_we, mem_addr, mem_wdata); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0)
            begin errors++; $display("FAIL reset_resp: got rdata=%h err=%b want 0/0", resp_rdata, resp_err); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_load();
        logic [16:0] exp_addr;
        ram[17'h10] = 8'h11; ram[17'h11] = 8'h22; ram[17'h12] = 8'h33; ram[17'h13] = 8'h44;
        issue(1'b0, 3'b001, 32'h0000_0010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_addr = 17'h10 + 17'(i);
            checks++; if (mem_addr !== exp_addr || mem_we !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0)
                begin errors++; $display("FAIL word_load_access%0d: got addr=%h we=%b busy=%b ready=%b want %h/0/1/0",
                                         i, mem_addr, mem_we, busy, req_ready, exp_addr); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h4433_2211 || resp_err !== 1'b0)
            begin errors++; $display("FAIL word_load_resp: got v=%b rdata=%h err=%b want 1/44332211/0",
                                     resp_valid, resp_rdata, resp_err); end
        tick();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            begin errors++; $display("FAIL word_load_idle: got ready=%b v=%b want 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_byte_loads();
        ram[17'h20] = 8'h80;
        issue(1'b0, 3'b011, 32'h0000_0020, 32'h0);
        checks++; if (mem_addr !== 17'h20 || resp_valid !== 1'b0)
            begin errors++; $display("FAIL byte_s_access: got addr=%h v=%b want 00020/0", mem_addr, resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL byte_signed: got v=%b rdata=%h want 1/ffffff80", resp_valid, resp_rdata); end
        tick();
        issue(1'b0, 3'b101, 32'h0000_0020, 32'h0);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080)
            begin errors++; $display("FAIL byte_unsigned: got v=%b rdata=%h want 1/00000080", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_half_load();
        ram[17'h31] = 8'hFE; ram[17'h32] = 8'hFF;
        issue(1'b0, 3'b010, 32'h0000_0031, 32'h0);
        tick(); tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL half_signed: got v=%b rdata=%h want 1/fffffffe", resp_valid, resp_rdata); end
        tick();
        issue(1'b0, 3'b100, 32'h0000_0031, 32'h0);
        tick(); tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_FFFE)
            begin errors++; $display("FAIL half_unsigned: got v=%b rdata=%h want 1/0000fffe", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_half_store_wrap();
        ram[17'h1FFFF] = 8'h00; ram[17'h00000] = 8'h00; ram[17'h00001] = 8'h00;
        issue(1'b1, 3'b010, 32'h0001_FFFF, 32'hABCD_1234);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h1FFFF || mem_wdata !== 8'h34)
            begin errors++; $display("FAIL store_byte0: got we=%b addr=%h data=%h want 1/1ffff/34", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h00000 || mem_wdata !== 8'h12)
            begin errors++; $display("FAIL store_byte1: got we=%b addr=%h data=%h want 1/00000/12", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_we !== 1'b0)
            begin errors++; $display("FAIL store_resp: got v=%b rdata=%h err=%b we=%b want 1/0/0/0",
                                     resp_valid, resp_rdata, resp_err, mem_we); end
        tick();
        checks++; if (ram[17'h1FFFF] !== 8'h34 || ram[17'h00000] !== 8'h12 || ram[17'h00001] !== 8'h00)
            begin errors++; $display("FAIL store_ram: got %h %h %h want 34 12 00",
                                     ram[17'h1FFFF], ram[17'h00000], ram[17'h00001]); end
    endtask

    task automatic test_illegal();
        issue(1'b1, 3'b111, 32'h0000_0050, 32'hFFFF_FFFF);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_we !== 1'b0 || resp_rdata !== 32'h0)
            begin errors++; $display("FAIL illegal_resp: got v=%b err=%b we=%b rdata=%h want 1/1/0/0",
                                     resp_valid, resp_err, mem_we, resp_rdata); end
        tick();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0)
            begin errors++; $display("FAIL illegal_idle: got ready=%b v=%b err=%b want 1/0/0", req_ready, resp_valid, resp_err); end
    endtask

    task automatic test_reset_mid_store();
        int seen_resp = 0;
        for (int i = 0; i < 4; i++) ram[17'h40 + 17'(i)] = 8'h00;
        issue(1'b1, 3'b001, 32'h0000_0040, 32'hDEAD_BEEF);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 17'h40 || mem_wdata !== 8'hEF)
            begin errors++; $display("FAIL rst_store_byte0: got we=%b addr=%h data=%h want 1/00040/ef", mem_we, mem_addr, mem_wdata); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_release: got ready=%b busy=%b want 1/0", req_ready, busy); end
        for (int i = 0; i < 5; i++) begin
            if (resp_valid === 1'b1) seen_resp++;
            tick();
        end
        checks++; if (seen_resp != 0) begin errors++; $display("FAIL rst_no_resp: got %0d pulses want 0", seen_resp); end
        checks++; if (ram[17'h40] !== 8'hEF || ram[17'h41] !== 8'h00 || ram[17'h42] !== 8'h00 || ram[17'h43] !== 8'h00)
            begin errors++; $display("FAIL rst_ram: got %h %h %h %h want ef 00 00 00",
                                     ram[17'h40], ram[17'h41], ram[17'h42], ram[17'h43]); end
    endtask

    task automatic test_back_to_back();
        ram[17'h20] = 8'h80;
        req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b101; req_addr = 32'h0000_0020; req_wdata = 32'h0;
        tick();
        tick();
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'h0000_0080)
            begin errors++; $display("FAIL b2b_first_resp: got v=%b ready=%b rdata=%h want 1/0/00000080",
                                     resp_valid, req_ready, resp_rdata); end
        tick();
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL b2b_idle: got ready=%b busy=%b want 1/0", req_ready, busy); end
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || mem_addr !== 17'h20)
            begin errors++; $display("FAIL b2b_second_accept: got busy=%b addr=%h want 1/00020", busy, mem_addr); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080)
            begin errors++; $display("FAIL b2b_second_resp: got v=%b rdata=%h want 1/00000080", resp_valid, resp_rdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        tick();
        test_word_load();
        test_byte_loads();
        test_half_load();
        test_half_store_wrap();
        test_illegal();
        test_reset_mid_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_byte_initiator.md
# mem_byte_initiator

Multi-cycle load/store initiator between the pipeline's memory stage and a byte-wide RAM port. It accepts one load or store request per transaction using a valid/ready handshake. It then performs one byte access per cycle in little-endian order, assembles and sign- or zero-extends load data, and returns a single-cycle response. It is the master side of the byte-addressed data memory interface and uses the same 3-bit access-mode encoding as the memory stage.

## Interface
- `WIDTH`, 32: request and response data width.
- `ADDR_BITS`, 17: byte address width of the RAM port; higher request address bits are ignored.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: initiator can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_mode` input 3: 001 word; 010 half signed; 011 byte signed; 100 half unsigned; 101 byte unsigned.
- `req_addr` input WIDTH: byte address; any alignment is legal.
- `req_wdata` input WIDTH: store data.
- `resp_valid` output 1: one-cycle completion pulse, for both loads and stores.
- `resp_rdata` output WIDTH: extended load data; 0 for stores and errors.
- `resp_err` output 1: illegal mode; qualified by `resp_valid`.
- `busy` output 1: a transaction is in flight (state ≠ IDLE).
- `mem_addr` output ADDR_BITS: RAM byte address.
- `mem_we` output 1: RAM byte write enable.
- `mem_wdata` output 8: RAM write byte.
- `mem_rdata` input 8: RAM read byte; combinational from `mem_addr`, sampled at the rising edge.

## Operation
- State machine states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `req_we`, `req_mode`, `req_addr[ADDR_BITS-1:0]` and `req_wdata`.
  - Clear the byte index and the assembly register.
- Legal mode, byte count N:
  - N = 4 for mode 001, 2 for modes 010/100, 1 for modes 011/101.
  - Stores with modes 100/101 behave as 010/011.
  - Next state is ACCESS.
- Illegal mode (000, 110, 111): go directly to RESP with `resp_err` = 1; no memory access occurs.
- ACCESS, byte index i = 0..N-1:
  - `mem_addr` = base + i, modulo 2^ADDR_BITS; 0x1FFFF + 1 wraps to 0x00000.
  - Stores: `mem_we` = 1 and `mem_wdata` = `wdata[8i+7:8i]`, i.e. little-endian, byte 0 at base.
  - Loads: `mem_we` = 0 and `mem_rdata` is captured into assembly byte i at the edge.
  - After i = N-1, go to RESP.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` is the extended assembly: signed modes replicate bit 7 of the top fetched byte; unsigned modes zero-fill.
  - Next state is IDLE. There is no response back-pressure; the consumer must take the pulse.
- Outside ACCESS:
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Outside RESP, `resp_valid`, `resp_err` and `resp_rdata` are 0.
- Requests are ignored unless the state is IDLE; there is no queueing.

## Timing
- Reset (`rst_n` low at an edge):
  - State goes to IDLE and all registers clear.
  - `req_ready` is gated low while `rst_n` = 0.
  - Every other output is 0.
- Reset mid-transaction:
  - The transaction aborts and no response is issued.
  - Bytes already written stay written; the remaining bytes are not written.
  - `req_ready` = 1 in the first cycle after `rst_n` returns high.
- Latency, with the request accepted at edge T:
  - ACCESS occupies cycles T+1..T+N.
  - `resp_valid` is high in cycle T+N+1.
  - `req_ready` is back high in cycle T+N+2.
- Illegal mode: `resp_valid` and `resp_err` are high in cycle T+1.
- Throughput: one transaction per N+2 cycles; the word-access worst case is 6 cycles.
- `req_valid` held high across completion: a new request is accepted in the first IDLE cycle after RESP.
- All outputs are registered state or decoded from state, index and latched fields. There is no combinational path from `req_*` to `mem_*`.

## Test plan
- Word load:
  - Setup: RAM[0x10..0x13] = 11,22,33,44; mode 001 at 0x10.
  - Expect: `mem_addr` 0x10..0x13 in T+1..T+4; `resp_rdata` = 0x44332211 at T+5; `resp_err` = 0.
- Byte loads:
  - Setup: RAM[0x20] = 0x80.
  - Expect: mode 011 → 0xFFFFFF80; mode 101 → 0x00000080; each response at T+2.
- Misaligned half load:
  - Setup: RAM[0x31] = 0xFE, RAM[0x32] = 0xFF; mode 010 at 0x31.
  - Expect: 0xFFFFFFFE. Mode 100 at 0x31 → 0x0000FFFE.
- Half store with address wrap:
  - Stimulus: mode 010, `req_wdata` = 0xABCD1234, address 0x1FFFF.
  - Expect: `mem_we` with 0x34 at 0x1FFFF in T+1, then 0x12 at 0x00000 in T+2; `resp_valid` at T+3 with `resp_rdata` = 0.
- Illegal mode:
  - Stimulus: mode 111.
  - Expect: `resp_valid` and `resp_err` = 1 at T+1; `mem_we` never asserted; `req_ready` high at T+2.
- Reset mid-store:
  - Stimulus: word store 0xDEADBEEF at 0x40; drive `rst_n` low for the edge ending cycle T+2.
  - Expect: only RAM[0x40] = 0xEF was written; no `resp_valid`; `req_ready` = 1 in the first cycle after release.
